// File: rtl/fruit_spawner_pkg.sv
// Shared types and constants for the fruit launch controller.
package fruit_pkg;

    localparam int SCR_W = 640;
    localparam int SCR_H = 480;
    localparam int X_MIN = 64;
    localparam int X_SPAN = 448;
    localparam int VY_MIN = 12;
    localparam int GRAV = 1;
    localparam int DLY_MIN = 8;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 expressed as register bit taps 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;
    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_POS = 2'b11;

    typedef enum logic [1:0] {IDLE, DELAY, LOAD, FLY} state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] vx;
        logic [9:0] vy;
        logic       dx;
        logic       dy;
        logic [9:0] ax;
        logic [9:0] ay;
        logic [1:0] adx;
        logic [1:0] ady;
    } launch_t;

endpackage

// File: rtl/fruit_spawner_if.sv
// Spawner <-> motion stage / blade detector signal bundle, plus FSM state for observation.
interface fruit_spawner_if;
    import fruit_pkg::*;

    // Load handshake: objload_n is a one-cycle low strobe; the init/accel values
    // are valid from the cycle after the strobe and held until the next strobe.
    logic       run, tick, oob1, oob2, sliced1, sliced2;
    logic       objload_n1, objload_n2, moveen1, moveen2, score_pulse;
    logic [9:0] initposx1, initposy1, initvx1, initvy1, ax1, ay1;
    logic [9:0] initposx2, initposy2, initvx2, initvy2, ax2, ay2;
    logic       initdx1, initdy1, initdx2, initdy2;
    logic [1:0] adx1, ady1, adx2, ady2;
    state_t     dbg_state1, dbg_state2;

    modport master (
        input  run, tick, oob1, oob2, sliced1, sliced2,
        output objload_n1, objload_n2, moveen1, moveen2, score_pulse,
        output initposx1, initposy1, initvx1, initvy1, initdx1, initdy1,
        output ax1, ay1, adx1, ady1,
        output initposx2, initposy2, initvx2, initvy2, initdx2, initdy2,
        output ax2, ay2, adx2, ady2,
        output dbg_state1, dbg_state2
    );

    modport slave (
        output run, tick, oob1, oob2, sliced1, sliced2,
        input  objload_n1, objload_n2, moveen1, moveen2, score_pulse,
        input  initposx1, initposy1, initvx1, initvy1, initdx1, initdy1,
        input  ax1, ay1, adx1, ady1,
        input  initposx2, initposy2, initvx2, initvy2, initdx2, initdy2,
        input  ax2, ay2, adx2, ady2,
        input  dbg_state1, dbg_state2
    );

endinterface

// File: rtl/fruit_spawner_slot.sv
// One launch slot: IDLE -> DELAY -> LOAD -> FLY FSM, re-launch delay and held launch values.
module spawn_slot
    import fruit_pkg::*;
#(
    parameter int P_SCR_H   = SCR_H,
    parameter int P_X_MIN   = X_MIN,
    parameter int P_X_SPAN  = X_SPAN,
    parameter int P_VY_MIN  = VY_MIN,
    parameter int P_GRAV    = GRAV,
    parameter int P_DLY_MIN = DLY_MIN
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_run,
    input  logic       i_tick,
    input  logic       i_grant,
    input  logic       i_oob,
    input  logic       i_sliced,
    input  logic [8:0] i_lfsr,
    output logic       o_req,
    output logic       o_load_n,
    output logic       o_moveen,
    output logic       o_hit,
    output launch_t    o_val,
    output state_t     o_state
);

    state_t     r_state, w_next;
    logic [6:0] r_dly;
    logic [1:0] r_settle;
    logic       r_oob_s1, r_oob_s2;
    launch_t    r_val, w_draw;
    logic [9:0] w_r;
    logic       w_grant, w_oob_edge;

    assign w_grant    = o_req & i_grant;
    // Motion stage flag needs two cycles after a load before its edge means anything
    assign w_oob_edge = r_oob_s1 & ~r_oob_s2 & (r_settle == 2'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!i_run) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next = DELAY;
                DELAY:   if (i_tick && r_dly == 7'd0) w_next = LOAD;
                LOAD:    if (w_grant) w_next = FLY;
                FLY:     if (i_sliced || w_oob_edge) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_req    = (r_state == LOAD) && i_run;
        o_load_n = ~w_grant;
        o_moveen = (r_state == FLY);
        o_hit    = (r_state == FLY) && i_sliced && i_run;
        o_val    = r_val;
        o_state  = r_state;
    end

    always_comb begin
        w_r        = {1'b0, i_lfsr};
        w_draw     = '0;
        w_draw.x   = 10'(P_X_MIN) + ((w_r >= 10'(P_X_SPAN)) ? (w_r - 10'(P_X_SPAN)) : w_r);
        w_draw.y   = 10'(P_SCR_H - 1);
        w_draw.vx  = {6'd0, i_lfsr[3:0]} + 10'd1;
        w_draw.dx  = i_lfsr[4];
        w_draw.vy  = 10'(P_VY_MIN) + {7'd0, i_lfsr[7:5]};
        w_draw.dy  = DIR_NEG;
        w_draw.ax  = 10'd0;
        w_draw.adx = ACC_NONE;
        w_draw.ay  = 10'(P_GRAV);
        w_draw.ady = ACC_POS;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dly    <= 7'd0;
            r_settle <= 2'd0;
            r_oob_s1 <= 1'b0;
            r_oob_s2 <= 1'b0;
            r_val    <= '0;
        end else begin
            r_oob_s1 <= i_oob;
            r_oob_s2 <= r_oob_s1;
            if (r_state == IDLE && i_run)
                r_dly <= 7'(P_DLY_MIN) + {1'b0, i_lfsr[5:0]};
            else if (r_state == DELAY && i_tick && r_dly != 7'd0)
                r_dly <= r_dly - 7'd1;
            if (w_grant) begin
                r_val    <= w_draw;
                r_settle <= 2'd2;
            end else if (r_state == FLY && r_settle != 2'd0) begin
                r_settle <= r_settle - 2'd1;
            end
        end
    end

endmodule

// File: rtl/fruit_spawner.sv
// Two-slot launch controller: shared LFSR, slot1-priority load arbitration, score pulse.
module fruit_spawner
    import fruit_pkg::*;
#(
    parameter int          P_SCR_H   = SCR_H,
    parameter int          P_X_MIN   = X_MIN,
    parameter int          P_X_SPAN  = X_SPAN,
    parameter int          P_VY_MIN  = VY_MIN,
    parameter int          P_GRAV    = GRAV,
    parameter int          P_DLY_MIN = DLY_MIN,
    parameter logic [15:0] P_SEED    = LFSR_SEED
) (
    input logic            clk,
    input logic            rstn,
    fruit_spawner_if.master bus
);

    logic [15:0] r_lfsr;
    logic        r_score_pulse;
    logic        w_req1, w_req2, w_grant1, w_grant2, w_hit1, w_hit2;
    logic        w_load_n1, w_load_n2, w_moveen1, w_moveen2;
    launch_t     w_val1, w_val2;
    state_t      w_state1, w_state2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lfsr        <= P_SEED;
            r_score_pulse <= 1'b0;
        end else begin
            r_lfsr        <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
            r_score_pulse <= w_hit1 | w_hit2;
        end
    end

    // Slot2 keeps requesting and picks up the following LFSR value one cycle later
    assign w_grant1 = w_req1;
    assign w_grant2 = w_req2 & ~w_req1;

    spawn_slot #(
        .P_SCR_H(P_SCR_H), .P_X_MIN(P_X_MIN), .P_X_SPAN(P_X_SPAN),
        .P_VY_MIN(P_VY_MIN), .P_GRAV(P_GRAV), .P_DLY_MIN(P_DLY_MIN)
    ) u_slot1 (
        .clk(clk), .rstn(rstn), .i_run(bus.run), .i_tick(bus.tick),
        .i_grant(w_grant1), .i_oob(bus.oob1), .i_sliced(bus.sliced1),
        .i_lfsr(r_lfsr[8:0]), .o_req(w_req1), .o_load_n(w_load_n1),
        .o_moveen(w_moveen1), .o_hit(w_hit1), .o_val(w_val1), .o_state(w_state1)
    );

    spawn_slot #(
        .P_SCR_H(P_SCR_H), .P_X_MIN(P_X_MIN), .P_X_SPAN(P_X_SPAN),
        .P_VY_MIN(P_VY_MIN), .P_GRAV(P_GRAV), .P_DLY_MIN(P_DLY_MIN)
    ) u_slot2 (
        .clk(clk), .rstn(rstn), .i_run(bus.run), .i_tick(bus.tick),
        .i_grant(w_grant2), .i_oob(bus.oob2), .i_sliced(bus.sliced2),
        .i_lfsr(r_lfsr[8:0]), .o_req(w_req2), .o_load_n(w_load_n2),
        .o_moveen(w_moveen2), .o_hit(w_hit2), .o_val(w_val2), .o_state(w_state2)
    );

    assign bus.objload_n1 = w_load_n1;
    assign bus.objload_n2 = w_load_n2;
    assign bus.moveen1    = w_moveen1;
    assign bus.moveen2    = w_moveen2;
    assign bus.score_pulse = r_score_pulse;
    assign bus.dbg_state1 = w_state1;
    assign bus.dbg_state2 = w_state2;

    assign bus.initposx1 = w_val1.x;
    assign bus.initposy1 = w_val1.y;
    assign bus.initvx1   = w_val1.vx;
    assign bus.initvy1   = w_val1.vy;
    assign bus.initdx1   = w_val1.dx;
    assign bus.initdy1   = w_val1.dy;
    assign bus.ax1       = w_val1.ax;
    assign bus.ay1       = w_val1.ay;
    assign bus.adx1      = w_val1.adx;
    assign bus.ady1      = w_val1.ady;

    assign bus.initposx2 = w_val2.x;
    assign bus.initposy2 = w_val2.y;
    assign bus.initvx2   = w_val2.vx;
    assign bus.initvy2   = w_val2.vy;
    assign bus.initdx2   = w_val2.dx;
    assign bus.initdy2   = w_val2.dy;
    assign bus.ax2       = w_val2.ax;
    assign bus.ay2       = w_val2.ay;
    assign bus.adx2      = w_val2.adx;
    assign bus.ady2      = w_val2.ady;

endmodule
